// File: rtl/fired_tag_fifo_pkg.sv
// Shared sizing for the fired-tag queue and its neighbours (neuron stage, SPU).
// The SPU and this queue must agree on TAGBITS.
package fired_tag_fifo_pkg;

  localparam int NUMNEURONS = 2;
  localparam int TAGBITS    = 1;
  localparam int DEPTH      = 2;
  localparam int PTRBITS    = 1;
  localparam int NUMWIDTH   = PTRBITS + 1;

  // True when a tag addresses a real neuron; larger tags are treated as duplicates.
  function automatic logic tag_in_range(input int tag, input int nneurons);
    return (tag >= 0) && (tag < nneurons);
  endfunction

endpackage

// File: rtl/fired_tag_fifo_if.sv
// Handshake bundle between the neuron stage / SPU (master) and the tag queue (slave).
interface fired_tag_fifo_if
  import fired_tag_fifo_pkg::*;
#(
  parameter int tagbits = TAGBITS,
  parameter int ptrbits = PTRBITS
) ();

  logic               enq;
  logic [tagbits-1:0] enq_tag;
  logic               req_deq;
  logic               clear_step;
  logic [tagbits-1:0] src_tag_out;
  logic               fifo_empty;
  logic               fifo_full;
  logic [ptrbits:0]   count;
  logic               overflow;
  logic               underflow;
  logic               dup_drop;

  modport master (
    output enq, enq_tag, req_deq, clear_step,
    input  src_tag_out, fifo_empty, fifo_full, count, overflow, underflow, dup_drop
  );

  modport slave (
    input  enq, enq_tag, req_deq, clear_step,
    output src_tag_out, fifo_empty, fifo_full, count, overflow, underflow, dup_drop
  );

endinterface

// File: rtl/fired_tag_fifo_bitmap.sv
// Per-timestep fired bitmap. Lookup sees the bitmap as already cleared when
// i_clear is high, so an enq in the boundary cycle belongs to the new step.
module fired_tag_fifo_bitmap
  import fired_tag_fifo_pkg::*;
#(
  parameter int numneurons = NUMNEURONS,
  parameter int tagbits    = TAGBITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_set,
  input  logic [tagbits-1:0] i_tag,
  output logic               o_hit
);

  logic [numneurons-1:0] r_bits;
  logic [numneurons-1:0] w_onehot;
  logic                  w_in_range;

  // Decode the tag into a one-hot neuron select and report already-fired / out-of-range.
  always_comb begin
    w_onehot   = '0;
    w_in_range = tag_in_range(int'(i_tag), numneurons);
    for (int i = 0; i < numneurons; i++) begin
      if (int'(i_tag) == i) w_onehot[i] = 1'b1;
    end
    o_hit = !w_in_range || (!i_clear && (|(r_bits & w_onehot)));
  end

  // Clear applies before set so a boundary-cycle enq marks the new step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bits <= '0;
    end else if (i_clear || i_set) begin
      r_bits <= (i_clear ? '0 : r_bits) | (i_set ? w_onehot : '0);
    end
  end

endmodule

// File: rtl/fired_tag_fifo.sv
// First-word-fall-through queue of spiking neuron tags feeding the SPU.
// Duplicate tags within a timestep are dropped; overflow/underflow are sticky.
module fired_tag_fifo
  import fired_tag_fifo_pkg::*;
#(
  parameter int numneurons = NUMNEURONS,
  parameter int tagbits    = TAGBITS,
  parameter int depth      = DEPTH,
  parameter int ptrbits    = PTRBITS
) (
  input  logic            clk,
  input  logic            asyn_reset,
  fired_tag_fifo_if.slave bus
);

  localparam logic [ptrbits:0] DEPTH_C = (ptrbits+1)'(depth);

  logic [tagbits-1:0] r_mem [depth];
  logic [ptrbits-1:0] r_rd_ptr;
  logic [ptrbits-1:0] r_wr_ptr;
  logic [ptrbits:0]   r_count;
  logic               r_overflow;
  logic               r_underflow;
  logic               r_dup_drop;

  logic w_empty;
  logic w_full;
  logic w_dup;
  logic w_do_deq;
  logic w_acc_enq;
  logic w_ovf_evt;
  logic w_unf_evt;

  fired_tag_fifo_bitmap #(
    .numneurons (numneurons),
    .tagbits    (tagbits)
  ) u_bitmap (
    .clk     (clk),
    .rst     (asyn_reset),
    .i_clear (bus.clear_step),
    .i_set   (w_acc_enq),
    .i_tag   (bus.enq_tag),
    .o_hit   (w_dup)
  );

  // Accept/dequeue decisions; a full queue still accepts when a pop frees a slot.
  always_comb begin
    w_empty   = (r_count == '0);
    w_full    = (r_count == DEPTH_C);
    w_do_deq  = bus.req_deq && !w_empty;
    w_acc_enq = bus.enq && !w_dup && (!w_full || w_do_deq);
    w_ovf_evt = bus.enq && !w_dup && w_full && !w_do_deq;
    w_unf_evt = bus.req_deq && w_empty;
  end

  // Pointers, occupancy and status flags; reset wins over any in-flight enq/deq.
  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_dup_drop  <= 1'b0;
    end else begin
      if (w_acc_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_deq)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_acc_enq && !w_do_deq) r_count <= r_count + 1'b1;
      else if (w_do_deq && !w_acc_enq) r_count <= r_count - 1'b1;
      if (w_ovf_evt) r_overflow  <= 1'b1;
      if (w_unf_evt) r_underflow <= 1'b1;
      r_dup_drop <= bus.enq && w_dup;
    end
  end

  // Tag storage; contents are only observable while the entry is counted valid.
  always_ff @(posedge clk) begin
    if (w_acc_enq) r_mem[r_wr_ptr] <= bus.enq_tag;
  end

  // Head is forced to zero while empty so the output is never X after reset.
  always_comb begin
    bus.src_tag_out = w_empty ? '0 : r_mem[r_rd_ptr];
    bus.fifo_empty  = w_empty;
    bus.fifo_full   = w_full;
    bus.count       = r_count;
    bus.overflow    = r_overflow;
    bus.underflow   = r_underflow;
    bus.dup_drop    = r_dup_drop;
  end

endmodule

// File: tb/tb_fired_tag_fifo.sv
// Bench for fired_tag_fifo: directed scenarios plus random traffic against a
// queue-based reference model of the tag queue.
module tb_fired_tag_fifo;
  import fired_tag_fifo_pkg::*;

  localparam int N  = 2;
  localparam int TB = 1;
  localparam int D  = 2;
  localparam int PB = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fired_tag_fifo_if #(.tagbits(TB), .ptrbits(PB)) bus ();

  fired_tag_fifo #(
    .numneurons (N),
    .tagbits    (TB),
    .depth      (D),
    .ptrbits    (PB)
  ) dut (
    .clk        (clk),
    .asyn_reset (rst),
    .bus        (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int q[$];
  bit fired[N];
  bit m_ovf, m_unf, m_dup;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < N; i++) fired[i] = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_dup = 1'b0;
  endtask

  task automatic check_outputs(input string where);
    chk({where, ".count"}, 32'(bus.count), 32'(q.size()));
    chk({where, ".empty"}, 32'(bus.fifo_empty), 32'(q.size() == 0));
    chk({where, ".full"}, 32'(bus.fifo_full), 32'(q.size() == D));
    chk({where, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
    chk({where, ".underflow"}, 32'(bus.underflow), 32'(m_unf));
    chk({where, ".dup_drop"}, 32'(bus.dup_drop), 32'(m_dup));
    if (q.size() > 0) chk({where, ".head"}, 32'(bus.src_tag_out), 32'(q[0]));
  endtask

  // One clock with the given inputs; the head is checked where the SPU samples it.
  task automatic cycle(input string where, input bit e, input int tag, input bit d, input bit c);
    bit dup, full, do_deq;
    bus.enq        = e;
    bus.enq_tag    = tag[TB-1:0];
    bus.req_deq    = d;
    bus.clear_step = c;
    if (d && q.size() > 0) chk({where, ".deq_head"}, 32'(bus.src_tag_out), 32'(q[0]));
    @(posedge clk);
    #1;
    if (c) for (int i = 0; i < N; i++) fired[i] = 1'b0;
    dup    = e && ((tag >= N) || fired[tag]);
    full   = (q.size() == D);
    do_deq = d && (q.size() > 0);
    if (d && q.size() == 0) m_unf = 1'b1;
    if (e && !dup && full && !do_deq) m_ovf = 1'b1;
    if (do_deq) void'(q.pop_front());
    if (e && !dup && (!full || do_deq)) begin
      q.push_back(tag);
      fired[tag] = 1'b1;
    end
    m_dup = e && dup;
    check_outputs(where);
  endtask

  task automatic idle(input string where);
    cycle(where, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string where, input bit e, input int tag, input bit d);
    rst            = 1'b1;
    bus.enq        = e;
    bus.enq_tag    = tag[TB-1:0];
    bus.req_deq    = d;
    bus.clear_step = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_outputs(where);
    chk({where, ".src_tag_out"}, 32'(bus.src_tag_out), 32'd0);
  endtask

  initial begin
    rst            = 1'b0;
    bus.enq        = 1'b0;
    bus.enq_tag    = '0;
    bus.req_deq    = 1'b0;
    bus.clear_step = 1'b0;
    model_reset();
    do_reset("reset", 1'b0, 0, 1'b0);

    // 1: single enq then deq
    cycle("t1_enq", 1'b1, 1, 1'b0, 1'b0);
    chk("t1_head", 32'(bus.src_tag_out), 32'd1);
    chk("t1_count", 32'(bus.count), 32'd1);
    cycle("t1_deq", 1'b0, 0, 1'b1, 1'b0);
    chk("t1_empty", 32'(bus.fifo_empty), 32'd1);

    // 2: duplicate within a step, then re-accept after clear_step
    cycle("t2_enq0", 1'b1, 0, 1'b0, 1'b0);
    cycle("t2_dup", 1'b1, 0, 1'b0, 1'b0);
    chk("t2_dup_pulse", 32'(bus.dup_drop), 32'd1);
    chk("t2_count1", 32'(bus.count), 32'd1);
    cycle("t2_clr", 1'b0, 0, 1'b0, 1'b1);
    cycle("t2_enq0b", 1'b1, 0, 1'b0, 1'b0);
    chk("t2_count2", 32'(bus.count), 32'd2);
    chk("t2_dup_gone", 32'(bus.dup_drop), 32'd0);

    // 3: overflow on full, then full accept with simultaneous deq
    do_reset("t3_reset", 1'b0, 0, 1'b0);
    cycle("t3_enq0", 1'b1, 0, 1'b0, 1'b0);
    cycle("t3_enq1", 1'b1, 1, 1'b0, 1'b0);
    cycle("t3_clr", 1'b0, 0, 1'b0, 1'b1);
    cycle("t3_ovf", 1'b1, 0, 1'b0, 1'b0);
    chk("t3_overflow", 32'(bus.overflow), 32'd1);
    chk("t3_count", 32'(bus.count), 32'd2);
    cycle("t3_swap", 1'b1, 0, 1'b1, 1'b0);
    chk("t3_swap_count", 32'(bus.count), 32'd2);
    chk("t3_swap_head", 32'(bus.src_tag_out), 32'd1);

    // 4: wrap through several enq/deq pairs
    do_reset("t4_reset", 1'b0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle("t4_enq", 1'b1, i % 2, 1'b0, 1'b1);
      chk("t4_order", 32'(bus.src_tag_out), 32'(i % 2));
      cycle("t4_deq", 1'b0, 0, 1'b1, 1'b0);
    end

    // 5: underflow is sticky
    cycle("t5_unf", 1'b0, 0, 1'b1, 1'b0);
    chk("t5_underflow", 32'(bus.underflow), 32'd1);
    idle("t5_idle");
    cycle("t5_after", 1'b1, 1, 1'b0, 1'b1);
    chk("t5_sticky", 32'(bus.underflow), 32'd1);

    // 6: reset with enq and deq in flight
    cycle("t6_fill", 1'b1, 0, 1'b0, 1'b0);
    do_reset("t6_reset", 1'b1, 0, 1'b1);
    chk("t6_underflow", 32'(bus.underflow), 32'd0);
    cycle("t6_reenq", 1'b1, 0, 1'b0, 1'b0);
    chk("t6_accepted", 32'(bus.count), 32'd1);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rnd_reset", 1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
                 1'($urandom_range(0, 1)));
      end else begin
        cycle("rnd", ($urandom_range(0, 9) < 6), int'($urandom_range(0, N - 1)),
              ($urandom_range(0, 9) < 5), ($urandom_range(0, 9) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
